shift_add_multiplier: RTL and testbench

- Unsigned var × var multiplier: iterative shift-and-add, one multiplier bit per clock.
- Counterpart to the iterative divider. Used where DSP blocks are scarce and operands change slowly, e.g. gain/scale factors in control paths.
- Unlike the divider, it has an explicit valid/ready handshake and a one-cycle result strobe.

---
 rtl/shift_add_multiplier.sv | 109 ++++++++++
 tb/tb_shift_add_multiplier.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: unsigned NBITS x NBITS iterative shift-and-add
// multiplier that consumes one multiplier bit per clock.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   valid_i        operands valid; accepted when valid_i && ready_o at an edge
//   multiplicand_i unsigned operand A (NBITS)
//   multiplier_i   unsigned operand B (NBITS)
//   ready_o        high while idle and able to accept operands
//   product_o      A*B (2*NBITS), registered, held until the next completion
//   valid_o        one-cycle strobe: product_o updated this cycle
//
// Optional build macro: SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
//   When defined, an operation finishes as soon as no set multiplier bits
//   remain, giving latency max(1, msb_index(B)+1). Results are unchanged.
module shift_add_multiplier #(
    parameter int NBITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [NBITS-1:0]     multiplicand_i,
    input  logic [NBITS-1:0]     multiplier_i,
    output logic                 ready_o,
    output logic [2*NBITS-1:0]   product_o,
    output logic                 valid_o
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t               r_state;
    logic [2*NBITS-1:0]   r_a_sh;
    logic [2*NBITS-1:0]   r_acc;
    logic [2*NBITS-1:0]   r_product;
    logic [NBITS-1:0]     r_b_sh;
    logic [CW-1:0]        r_cnt;
    logic                 r_valid;
    logic                 r_ready;

    logic [2*NBITS-1:0]   w_sum;
    logic                 w_done;

    // Partial products never overflow: the final product fits in 2*NBITS.
    assign w_sum = r_acc + (r_b_sh[0] ? r_a_sh : '0);

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    // Stop once the remaining multiplier bits above bit 0 are all zero.
    assign w_done = (r_cnt == LAST) || (r_b_sh[NBITS-1:1] == '0);
`else
    assign w_done = (r_cnt == LAST);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_b_sh    <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (valid_i) begin
                        r_a_sh  <= {{NBITS{1'b0}}, multiplicand_i};
                        r_b_sh  <= multiplier_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_product <= w_sum;
                        r_valid   <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_acc  <= w_sum;
                        r_a_sh <= r_a_sh << 1;
                        r_b_sh <= r_b_sh >> 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = r_ready;
    assign product_o = r_product;
    assign valid_o   = r_valid;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed self-checking bench, NBITS=8.
// Expected latencies follow SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN.
module tb_shift_add_multiplier;

    localparam int NB = 8;

    logic            clk;
    logic            rst;
    logic            valid_i;
    logic [NB-1:0]   a_i;
    logic [NB-1:0]   b_i;
    logic            ready_o;
    logic [2*NB-1:0] product_o;
    logic            valid_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    shift_add_multiplier #(.NBITS(NB)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .valid_i        (valid_i),
        .multiplicand_i (a_i),
        .multiplier_i   (b_i),
        .ready_o        (ready_o),
        .product_o      (product_o),
        .valid_o        (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus helper: called #1 after an edge with ready_o high.
    // Returns product, edges from accept to valid_o (-1 on timeout),
    // and whether ready_o stayed low for every busy cycle.
    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          output logic [2*NB-1:0] prod, output int lat,
                          output bit busy_ok);
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        a_i = ~a;
        b_i = ~b;
        lat = -1;
        busy_ok = !ready_o;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                lat = n;
                break;
            end
            if (ready_o) busy_ok = 0;
        end
        prod = product_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", ready_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", valid_o);
        end
        checks++;
        if (product_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_product got=%0d exp=0", product_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [2*NB-1:0] p;
        int lat;
        bit bok;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        int exp_lat = 4;
`else
        int exp_lat = 8;
`endif
        run_op(8'd13, 8'd11, p, lat, bok);
        checks++;
        if (p !== 16'd143) begin
            errors++;
            $display("FAIL basic_product got=%0d exp=143", p);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL basic_ready_busy got=high exp=low");
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_at_valid got=%b exp=1", ready_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_strobe_width got=%b exp=0", valid_o);
        end
    endtask

    task automatic test_hold();
        int bad_v = 0;
        int bad_p = 0;
        valid_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            a_i = 8'(i * 7);
            b_i = 8'(i * 3);
            @(posedge clk);
            #1;
            if (valid_o !== 1'b0) bad_v++;
            if (product_o !== 16'd143) bad_p++;
        end
        checks++;
        if (bad_v != 0) begin
            errors++;
            $display("FAIL hold_valid got=%0d pulses exp=0", bad_v);
        end
        checks++;
        if (bad_p != 0) begin
            errors++;
            $display("FAIL hold_product got=%0d exp=143", product_o);
        end
    endtask

    task automatic test_max();
        logic [2*NB-1:0] p;
        int lat;
        bit bok;
        run_op(8'd255, 8'd255, p, lat, bok);
        checks++;
        if (p !== 16'd65025) begin
            errors++;
            $display("FAIL max_product got=%0d exp=65025", p);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL max_latency got=%0d exp=8", lat);
        end
        run_op(8'd0, 8'd200, p, lat, bok);
        checks++;
        if (p !== 16'd0) begin
            errors++;
            $display("FAIL zero_a_product got=%0d exp=0", p);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL zero_a_latency got=%0d exp=8", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0]   va [3] = '{8'd3, 8'd100, 8'd17};
        logic [NB-1:0]   vb [3] = '{8'd5, 8'd7, 8'd17};
        logic [2*NB-1:0] ve [3] = '{16'd15, 16'd700, 16'd289};
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        int gap [3] = '{0, 4, 6};
`else
        int gap [3] = '{0, 9, 9};
`endif
        int t_prev = 0;
        bit seen;
        valid_i = 1'b1;
        a_i = va[0];
        b_i = vb[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            seen = 0;
            for (int n = 0; n < 40; n++) begin
                if (valid_o) begin
                    seen = 1;
                    break;
                end
                a_i = 8'hA5;
                b_i = 8'hFF;
                @(posedge clk);
                #1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL b2b_timeout[%0d] got=none exp=pulse", k);
            end
            checks++;
            if (product_o !== ve[k]) begin
                errors++;
                $display("FAIL b2b_product[%0d] got=%0d exp=%0d",
                         k, product_o, ve[k]);
            end
            if (k > 0) begin
                checks++;
                if (cyc - t_prev != gap[k]) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d",
                             k, cyc - t_prev, gap[k]);
                end
            end
            t_prev = cyc;
            if (k < 2) begin
                a_i = va[k+1];
                b_i = vb[k+1];
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [2*NB-1:0] p;
        int lat;
        bit bok;
        int pulses = 0;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        int exp_lat = 2;
`else
        int exp_lat = 8;
`endif
        valid_i = 1'b1;
        a_i = 8'd200;
        b_i = 8'd200;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (product_o !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_product got=%0d exp=0", product_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got=%b exp=1", ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstmid_no_valid got=%0d exp=0", pulses);
        end
        run_op(8'd2, 8'd3, p, lat, bok);
        checks++;
        if (p !== 16'd6) begin
            errors++;
            $display("FAIL rstmid_after got=%0d exp=6", p);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL rstmid_after_lat got=%0d exp=%0d", lat, exp_lat);
        end
    endtask

    task automatic test_early_exit();
        logic [NB-1:0]   vb [3] = '{8'd3, 8'd0, 8'd128};
        logic [2*NB-1:0] ve [3] = '{16'd600, 16'd0, 16'd25600};
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        int el [3] = '{2, 1, 8};
`else
        int el [3] = '{8, 8, 8};
`endif
        logic [2*NB-1:0] p;
        int lat;
        bit bok;
        for (int k = 0; k < 3; k++) begin
            run_op(8'd200, vb[k], p, lat, bok);
            checks++;
            if (p !== ve[k]) begin
                errors++;
                $display("FAIL early_product[%0d] got=%0d exp=%0d",
                         k, p, ve[k]);
            end
            checks++;
            if (lat != el[k]) begin
                errors++;
                $display("FAIL early_latency[%0d] got=%0d exp=%0d",
                         k, lat, el[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_max();
        test_back_to_back();
        test_reset_mid();
        test_early_exit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
